// File: rtl/speed_decode_pkg.sv
// speed_decode_pkg: nominal phase lengths, mode codes, FSM states, tolerance window
package speed_decode_pkg;

  localparam logic [21:0] LO_SLOW_NOM = 22'h1406f4;
  localparam logic [21:0] LO_MED_NOM  = 22'h0d59f8;
  localparam logic [21:0] LO_FAST_NOM = 22'h06acfc;
  localparam logic [21:0] HI_SLOW_NOM = 22'h280de8;
  localparam logic [21:0] HI_MED_NOM  = 22'h1ab3f0;
  localparam logic [21:0] HI_FAST_NOM = 22'h0d59f8;
  localparam logic [21:0] TOL_NOM     = 22'd20000;
  localparam logic [21:0] TIMEOUT_NOM = 22'h3fffff;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_SLOW = 3'b001;
  localparam logic [2:0] MODE_MED  = 3'b010;
  localparam logic [2:0] MODE_FAST = 3'b100;

  typedef enum logic [1:0] {
    S_WAIT,
    S_PH1,
    S_PH2,
    S_LOCK
  } state_t;

  // Window [nom-tol, nom+tol] in 23 bits; the lower bound clamps at zero.
  function automatic logic in_window(input logic [22:0] dur,
                                     input logic [21:0] nom,
                                     input logic [21:0] tol);
    logic [22:0] lo;
    logic [22:0] hi;
    lo = (nom >= tol) ? {1'b0, nom - tol} : '0;
    hi = {1'b0, nom} + {1'b0, tol};
    return (dur >= lo) && (dur <= hi);
  endfunction

endpackage

// File: rtl/speed_decode_phase_classify.sv
// phase_classify: maps a measured phase (duration, level) to a one-hot mode or 000
module phase_classify
  import speed_decode_pkg::*;
#(
  parameter logic [21:0] LO_SLOW = LO_SLOW_NOM,
  parameter logic [21:0] LO_MED  = LO_MED_NOM,
  parameter logic [21:0] LO_FAST = LO_FAST_NOM,
  parameter logic [21:0] HI_SLOW = HI_SLOW_NOM,
  parameter logic [21:0] HI_MED  = HI_MED_NOM,
  parameter logic [21:0] HI_FAST = HI_FAST_NOM,
  parameter logic [21:0] TOL     = TOL_NOM
) (
  input  logic [22:0] dur,
  input  logic        level,
  output logic [2:0]  cls
);

  always_comb begin
    cls = MODE_NONE;
    if (level) begin
      if (in_window(dur, HI_SLOW, TOL))      cls = MODE_SLOW;
      else if (in_window(dur, HI_MED, TOL))  cls = MODE_MED;
      else if (in_window(dur, HI_FAST, TOL)) cls = MODE_FAST;
    end else begin
      if (in_window(dur, LO_SLOW, TOL))      cls = MODE_SLOW;
      else if (in_window(dur, LO_MED, TOL))  cls = MODE_MED;
      else if (in_window(dur, LO_FAST, TOL)) cls = MODE_FAST;
    end
  end

endmodule

// File: rtl/speed_decode.sv
// speed_decode: recovers the one-hot blink-speed mode from phase lengths of sig_in
module speed_decode
  import speed_decode_pkg::*;
#(
  parameter logic [21:0] LO_SLOW = LO_SLOW_NOM,
  parameter logic [21:0] LO_MED  = LO_MED_NOM,
  parameter logic [21:0] LO_FAST = LO_FAST_NOM,
  parameter logic [21:0] HI_SLOW = HI_SLOW_NOM,
  parameter logic [21:0] HI_MED  = HI_MED_NOM,
  parameter logic [21:0] HI_FAST = HI_FAST_NOM,
  parameter logic [21:0] TOL     = TOL_NOM,
  parameter logic [21:0] TIMEOUT = TIMEOUT_NOM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  output logic [2:0] mode,
  output logic       mode_valid,
  output logic       mode_stb,
  output logic       err,
  output logic       lost
);

  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic [2:0]  fill;
  logic        edge_pulse;
  logic        ended_level;
  logic [21:0] count;
  logic [22:0] dur;
  logic [2:0]  cls;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cand;
  logic [2:0]  cand_nx;
  logic [2:0]  mode_nx;
  logic        valid_nx;
  logic        stb_nx;
  logic        err_nx;
  logic        lost_nx;

  // fill gates edge detection until the synchronizer holds real samples, so the
  // reset value of the flops never fakes a transition when sig_in is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      fill        <= '0;
      edge_pulse  <= 1'b0;
      ended_level <= 1'b0;
    end else begin
      sync1       <= sig_in;
      sync2       <= sync1;
      sync3       <= sync2;
      fill        <= {fill[1:0], 1'b1};
      edge_pulse  <= fill[2] & (sync2 ^ sync3);
      ended_level <= sync3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (edge_pulse) begin
      count <= '0;
    end else if (count != TIMEOUT) begin
      count <= count + 22'd1;
    end
  end

  assign dur = {1'b0, count} + 23'd1;

  phase_classify #(
    .LO_SLOW (LO_SLOW),
    .LO_MED  (LO_MED),
    .LO_FAST (LO_FAST),
    .HI_SLOW (HI_SLOW),
    .HI_MED  (HI_MED),
    .HI_FAST (HI_FAST),
    .TOL     (TOL)
  ) u_classify (
    .dur   (dur),
    .level (ended_level),
    .cls   (cls)
  );

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    mode_nx  = mode;
    valid_nx = mode_valid;
    stb_nx   = 1'b0;
    err_nx   = 1'b0;
    lost_nx  = lost;
    if (edge_pulse) begin
      lost_nx = 1'b0;
      case (state)
        S_WAIT: state_nx = S_PH1;
        S_PH1: begin
          if (cls != MODE_NONE) begin
            cand_nx  = cls;
            state_nx = S_PH2;
          end else begin
            err_nx = 1'b1;
          end
        end
        S_PH2: begin
          if (cls == MODE_NONE) begin
            err_nx   = 1'b1;
            state_nx = S_PH1;
          end else if (cls == cand) begin
            mode_nx  = cand;
            valid_nx = 1'b1;
            stb_nx   = 1'b1;
            state_nx = S_LOCK;
          end else begin
            cand_nx = cls;
          end
        end
        S_LOCK: begin
          if (cls == MODE_NONE) begin
            err_nx   = 1'b1;
            valid_nx = 1'b0;
            mode_nx  = MODE_NONE;
            state_nx = S_PH1;
          end else if (cls != mode) begin
            valid_nx = 1'b0;
            mode_nx  = MODE_NONE;
            cand_nx  = cls;
            state_nx = S_PH2;
          end
        end
        default: state_nx = S_WAIT;
      endcase
    end else if ((state != S_WAIT) && (count == TIMEOUT)) begin
      lost_nx  = 1'b1;
      valid_nx = 1'b0;
      mode_nx  = MODE_NONE;
      state_nx = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_WAIT;
      cand       <= MODE_NONE;
      mode       <= MODE_NONE;
      mode_valid <= 1'b0;
      mode_stb   <= 1'b0;
      err        <= 1'b0;
      lost       <= 1'b0;
    end else begin
      state      <= state_nx;
      cand       <= cand_nx;
      mode       <= mode_nx;
      mode_valid <= valid_nx;
      mode_stb   <= stb_nx;
      err        <= err_nx;
      lost       <= lost_nx;
    end
  end

endmodule

// File: tb/tb_speed_decode.sv
// tb_speed_decode: phase-level reference model against speed_decode with small nominals
module tb_speed_decode;

  localparam int TOL = 3;
  localparam int TMO = 200;

  int lo_nom [3] = '{40, 30, 20};
  int hi_nom [3] = '{80, 60, 40};

  logic       clk;
  logic       reset;
  logic       sig_in;
  logic [2:0] mode;
  logic       mode_valid;
  logic       mode_stb;
  logic       err;
  logic       lost;
  logic [6:0] obs;

  int total;
  int bad;

  bit         synced;
  int         run_len;
  int         run_mode;
  int         cur_len;
  logic [6:0] exp_vec;

  speed_decode #(
    .LO_SLOW (22'd40),
    .LO_MED  (22'd30),
    .LO_FAST (22'd20),
    .HI_SLOW (22'd80),
    .HI_MED  (22'd60),
    .HI_FAST (22'd40),
    .TOL     (22'd3),
    .TIMEOUT (22'd200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_stb   (mode_stb),
    .err        (err),
    .lost       (lost)
  );

  assign obs = {mode, mode_valid, mode_stb, err, lost};

  always #5 clk = ~clk;

  function automatic int nom_len(input int m, input logic lvl);
    return lvl ? hi_nom[m] : lo_nom[m];
  endfunction

  // Mode index whose nominal for this level is within tolerance, else -1.
  function automatic int classify(input logic lvl, input int d);
    for (int m = 0; m < 3; m++) begin
      if (d >= nom_len(m, lvl) - TOL && d <= nom_len(m, lvl) + TOL) return m;
    end
    return -1;
  endfunction

  // A lock is a run of at least two consecutive phases of the same class.
  task automatic model_update(input logic lvl, input int d);
    int c;
    logic [2:0] m3;
    logic s;
    logic e;
    s = 1'b0;
    e = 1'b0;
    if (!synced || d > TMO + 1) begin
      synced  = 1'b1;
      run_len = 0;
    end else begin
      c = classify(lvl, d);
      if (c < 0) begin
        e = 1'b1;
        run_len = 0;
      end else if (run_len > 0 && c == run_mode) begin
        run_len++;
        s = (run_len == 2);
      end else begin
        run_mode = c;
        run_len  = 1;
      end
    end
    m3 = 3'b000;
    if (run_len >= 2) m3[run_mode] = 1'b1;
    exp_vec = {m3, run_len >= 2, s, e, 1'b0};
  endtask

  task automatic model_reset();
    synced  = 1'b0;
    run_len = 0;
  endtask

  // Ends the current phase with a transition, then waits to the output cycle.
  task automatic begin_phase(input int len);
    model_update(sig_in, cur_len);
    sig_in  = ~sig_in;
    cur_len = len;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic end_phase();
    repeat (cur_len - 5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", obs, 7'b0);
    end
    sig_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL reset_hold: got %b want %b", obs, 7'b0);
    end
    sig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_fast_lock();
    int lens [6] = '{40, 20, 40, 20, 40, 20};
    for (int i = 0; i < 6; i++) begin
      begin_phase(lens[i]);
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL fast_lock[%0d]: got %b want %b", i, obs, exp_vec);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mode_stb, err} !== 2'b00) begin
        bad++;
        $display("FAIL fast_lock_pulse[%0d]: got %b want 00", i, {mode_stb, err});
      end
      end_phase();
    end
  endtask

  task automatic test_mode_switch();
    int modes [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
    for (int i = 0; i < 10; i++) begin
      begin_phase(nom_len(modes[i], ~sig_in));
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL mode_switch[%0d]: got %b want %b", i, obs, exp_vec);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mode_stb, err} !== 2'b00) begin
        bad++;
        $display("FAIL mode_switch_pulse[%0d]: got %b want 00", i, {mode_stb, err});
      end
      end_phase();
    end
  endtask

  task automatic test_tolerance();
    int deltas [14] = '{0, 0, 0, 3, -3, 3, -3, 4, 0, 0, 0, -4, 0, 0};
    for (int i = 0; i < 14; i++) begin
      begin_phase(nom_len(1, ~sig_in) + deltas[i]);
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL tolerance[%0d]: got %b want %b", i, obs, exp_vec);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mode_stb, err} !== 2'b00) begin
        bad++;
        $display("FAIL tolerance_pulse[%0d]: got %b want 00", i, {mode_stb, err});
      end
      end_phase();
    end
  endtask

  task automatic test_bad_phase();
    int i;
    bit injected;
    i = 0;
    injected = 1'b0;
    while (i < 12) begin
      if (!injected && i >= 4 && sig_in == 1'b1) begin
        begin_phase(25);
        injected = 1'b1;
      end else begin
        begin_phase(nom_len(1, ~sig_in));
      end
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL bad_phase[%0d]: got %b want %b", i, obs, exp_vec);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mode_stb, err} !== 2'b00) begin
        bad++;
        $display("FAIL bad_phase_pulse[%0d]: got %b want 00", i, {mode_stb, err});
      end
      end_phase();
      i++;
    end
  endtask

  task automatic test_lost();
    int i;
    i = 0;
    while (i < 4 || sig_in == 1'b1) begin
      begin_phase(nom_len(1, ~sig_in));
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL lost_lock[%0d]: got %b want %b", i, obs, exp_vec);
      end
      end_phase();
      i++;
    end
    begin_phase(250);
    total++;
    if (obs !== exp_vec) begin
      bad++;
      $display("FAIL lost_start: got %b want %b", obs, exp_vec);
    end
    repeat (200) @(posedge clk);
    #1;
    total++;
    if (lost !== 1'b0) begin
      bad++;
      $display("FAIL lost_early: got %b want 0", lost);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL lost_set: got %b want %b", obs, 7'b0000001);
    end
    repeat (45) @(posedge clk);
    #1;
    total++;
    if (obs !== 7'b0000001) begin
      bad++;
      $display("FAIL lost_hold: got %b want %b", obs, 7'b0000001);
    end
    for (int k = 0; k < 4; k++) begin
      begin_phase(nom_len(2, ~sig_in));
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL lost_recover[%0d]: got %b want %b", k, obs, exp_vec);
      end
      end_phase();
    end
  endtask

  task automatic test_edge_timeout();
    int lens [4] = '{TMO + 1, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      begin_phase(lens[i] != 0 ? lens[i] : nom_len(2, ~sig_in));
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL edge_timeout[%0d]: got %b want %b", i, obs, exp_vec);
      end
      end_phase();
    end
    begin_phase(nom_len(2, ~sig_in));
    total++;
    if (obs !== exp_vec) begin
      bad++;
      $display("FAIL edge_timeout_after: got %b want %b", obs, exp_vec);
    end
    end_phase();
  endtask

  task automatic test_reset_midphase();
    int i;
    i = 0;
    while (i < 4 || sig_in == 1'b1) begin
      begin_phase(nom_len(0, ~sig_in));
      end_phase();
      i++;
    end
    begin_phase(80);
    total++;
    if (obs !== exp_vec) begin
      bad++;
      $display("FAIL rst_mid_locked: got %b want %b", obs, exp_vec);
    end
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_clear: got %b want %b", obs, 7'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      begin_phase(nom_len(0, ~sig_in));
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL rst_mid_resume[%0d]: got %b want %b", k, obs, exp_vec);
      end
      end_phase();
    end
  endtask

  task automatic test_random();
    int m;
    int r;
    int len;
    m = int'($urandom_range(0, 2));
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) m = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      len = nom_len(m, ~sig_in);
      if (r == 0) len = len + int'($urandom_range(0, 10)) - 5;
      else if (r == 1) len = int'($urandom_range(15, 100));
      else if (r == 2) len = len + int'($urandom_range(0, 6)) - 3;
      begin_phase(len);
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL random[%0d]: got %b want %b", i, obs, exp_vec);
      end
      @(posedge clk);
      #1;
      total++;
      if ({mode_stb, err} !== 2'b00) begin
        bad++;
        $display("FAIL random_pulse[%0d]: got %b want 00", i, {mode_stb, err});
      end
      end_phase();
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    sig_in   = 1'b0;
    total    = 0;
    bad      = 0;
    synced   = 1'b0;
    run_len  = 0;
    run_mode = 0;
    cur_len  = 0;
    exp_vec  = '0;
    test_reset();
    test_fast_lock();
    test_mode_switch();
    test_tolerance();
    test_bad_phase();
    test_lost();
    test_edge_timeout();
    test_reset_midphase();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
